// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and its mult/div timer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN = 1'b0,
    MD  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W       = 6;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Counter preload: the first busy cycle already holds LAT-1, so the last one holds 0.
  function automatic logic [CNT_W-1:0] md_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard status in, pipeline register controls out, grouped for pipe_ctrl.
interface pipe_ctrl_if;

  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        id_md_op;
  logic        id_md_div;
  logic        id_hilo_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        dmem_ready;

  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        exmem_write;
  logic        ifid_flush;
  logic        ex_bubble;
  logic        md_start;
  logic        md_busy;
  logic        hilo_we;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  pipe_ctrl_pkg::md_state_e md_state;

  // Mult/div handshake: md_start is a one-cycle launch accepted only while md_busy
  // is low; md_busy then stays high for exactly LAT cycles and hilo_we pulses in
  // the last of them. No other launch can be accepted until md_busy drops.
  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, id_md_op, id_md_div,
           id_hilo_rd, ex_branch_taken, mem_req, dmem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush, ex_bubble,
           md_start, md_busy, hilo_we, stall_cycles, flush_count, md_state
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, id_md_op, id_md_div,
           id_hilo_rd, ex_branch_taken, mem_req, dmem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush, ex_bubble,
           md_start, md_busy, hilo_we, stall_cycles, flush_count, md_state
  );

endinterface

// File: rtl/pipe_ctrl_md_timer.sv
// Occupancy timer for the shared mult/div unit: tracks busy cycles and times the HI/LO write.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      md_start,
  input  logic      md_div,
  output logic      md_busy,
  output logic      hilo_we,
  output md_state_e state
);

  localparam logic [CNT_W-1:0] MUL_LD  = md_load(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = md_load(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  assign load_val = md_div ? DIV_LD : MUL_LD;

  // hilo_we is registered one step ahead so it lands in the cycle cnt reaches 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      md_busy <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            state   <= MD;
            cnt     <= load_val;
            md_busy <= 1'b1;
            hilo_we <= (load_val == '0);
          end
        end
        MD: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_ONE;
            hilo_we <= (cnt == CNT_ONE);
          end else begin
            state   <= RUN;
            md_busy <= 1'b0;
            hilo_we <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          md_busy <= 1'b0;
          hilo_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline, plus mult/div occupancy.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  pipe_ctrl_if.slave bus
);

  logic      run_q;
  logic      freeze, load_use, md_hazard;
  logic      pc_write, ifid_write, idex_write, exmem_write;
  logic      ifid_flush, ex_bubble, md_start;
  logic      md_busy, hilo_we;
  md_state_e md_state;

  // Holds the reset controls until the first clock edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign freeze    = bus.mem_req && !bus.dmem_ready;
  assign load_use  = bus.idex_memread && (bus.idex_rt != REG_ZERO) &&
                     ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
  assign md_hazard = md_busy && (bus.id_md_op || bus.id_hilo_rd);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    ex_bubble   = 1'b0;
    md_start    = 1'b0;
    if (!run_q) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      ex_bubble   = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      ex_bubble   = 1'b1;
    end else if (load_use || md_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ex_bubble   = 1'b1;
    end else if (bus.id_md_op) begin
      md_start    = 1'b1;
    end
  end

  md_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_div   (bus.id_md_div),
    .md_busy  (md_busy),
    .hilo_we  (hilo_we),
    .state    (md_state)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (run_q && !pc_write && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (run_q && ifid_flush && (flush_q != '1)) flush_q <= flush_q + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.idex_write  = idex_write;
  assign bus.exmem_write = exmem_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.ex_bubble   = ex_bubble;
  assign bus.md_start    = md_start;
  assign bus.md_busy     = md_busy;
  assign bus.hilo_we     = hilo_we;
  assign bus.md_state    = md_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: time-based mult/div model plus rule table, directed pins and random traffic.
module tb_pipe_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
  localparam int W     = 9 + 32 + 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  // Model: a mult/div launched in cycle md_t0 occupies cycles md_t0+1 .. md_t0+md_lat.
  int          cyc     = 0;
  int          md_t0   = -1000;
  int          md_lat  = 0;
  bit          in_rst  = 1'b1;
  logic [31:0] stall_m = '0;
  logic [15:0] flush_m = '0;
  logic [8:0]  cur_exp = '0;

  // Control vector order: pc, ifid, idex, exmem, flush, bubble, start, busy, hilo
  function automatic logic [8:0] dut_ctrl();
    return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
            bus.ifid_flush, bus.ex_bubble, bus.md_start, bus.md_busy, bus.hilo_we};
  endfunction

  function automatic logic [8:0] model_ctrl();
    logic [3:0] en;
    logic flush, bub, start, busy, hilo, lu;
    busy  = !in_rst && (cyc > md_t0) && (cyc <= md_t0 + md_lat);
    hilo  = busy && (cyc == md_t0 + md_lat);
    en    = 4'b1111;
    flush = 1'b0;
    bub   = 1'b0;
    start = 1'b0;
    lu    = bus.idex_memread && (bus.idex_rt != 5'd0) &&
            ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
    if (in_rst) begin
      en = 4'b0000; flush = 1'b1; bub = 1'b1;
    end else if (bus.mem_req && !bus.dmem_ready) begin
      en = 4'b0000;
    end else if (bus.ex_branch_taken) begin
      flush = 1'b1; bub = 1'b1;
    end else if (lu || (busy && (bus.id_md_op || bus.id_hilo_rd))) begin
      en = 4'b0011; bub = 1'b1;
    end else if (bus.id_md_op) begin
      start = 1'b1;
    end
    return {en, flush, bub, start, busy, hilo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Advance the model at each edge, then predict the cycle once the driver has settled.
  always @(posedge clk) begin
    if (!in_rst) begin
      if (cur_exp[2]) begin
        md_t0  = cyc;
        md_lat = bus.id_md_div ? DIV_L : MUL_L;
      end
      if (!cur_exp[8] && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (cur_exp[4] && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
    end
    if (rst_n) in_rst = 1'b0;
    cyc++;
    #2;
    if (!rst_n) begin
      in_rst  = 1'b1;
      md_t0   = -1000;
      stall_m = '0;
      flush_m = '0;
    end
    cur_exp = model_ctrl();
`ifdef PIPE_CTRL_PERF_EN
    exp_q.push_back({cur_exp, stall_m, flush_m});
`else
    exp_q.push_back({cur_exp, 32'd0, 16'd0});
`endif
  end

  // Compare process: one full check per cycle, mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl", 32'(dut_ctrl()), 32'(e[W-1:48]));
      chk("stall_cycles", bus.stall_cycles, e[47:16]);
      chk("flush_count", 32'(bus.flush_count), 32'(e[15:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.idex_memread    = 1'b0;
    bus.idex_rt         = 5'd0;
    bus.ifid_rs         = 5'd0;
    bus.ifid_rt         = 5'd0;
    bus.id_md_op        = 1'b0;
    bus.id_md_div       = 1'b0;
    bus.id_hilo_rd      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_req         = 1'b0;
    bus.dmem_ready      = 1'b1;
  endtask

  task automatic pin(input string name, input logic [8:0] exp);
    #3;
    chk(name, 32'(dut_ctrl()), 32'(exp));
  endtask

  task automatic random_inputs();
    bus.idex_memread    = ($urandom_range(0, 2) == 0);
    bus.idex_rt         = 5'($urandom_range(0, 3));
    bus.ifid_rs         = 5'($urandom_range(0, 3));
    bus.ifid_rt         = 5'($urandom_range(0, 3));
    bus.id_md_op        = ($urandom_range(0, 5) == 0);
    bus.id_md_div       = ($urandom_range(0, 3) == 0);
    bus.id_hilo_rd      = ($urandom_range(0, 5) == 0);
    bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
    bus.mem_req         = ($urandom_range(0, 2) == 0);
    bus.dmem_ready      = ($urandom_range(0, 1) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    next();
    next();
    pin("reset_ctrl", 9'b000011000);
    chk("reset_stall_cnt", bus.stall_cycles, 32'd0);
    chk("reset_flush_cnt", 32'(bus.flush_count), 32'd0);

    next(); rst_n = 1'b1;
    pin("release_cycle", 9'b000011000);
    next();
    pin("first_run", 9'b111100000);

    // Load-use on r8, then the bubble clears it; r0 never stalls.
    next(); bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    pin("load_use", 9'b001101000);
    next(); bus.idex_memread = 1'b0;
    pin("after_bubble", 9'b111100000);
    next(); bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    pin("load_r0", 9'b111100000);

    // mult then mfhi waiting on HI/LO.
    next(); idle_inputs(); bus.id_md_op = 1'b1;
    pin("mult_issue", 9'b111100100);
    next(); bus.id_md_op = 1'b0; bus.id_hilo_rd = 1'b1;
    pin("mfhi_stall1", 9'b001101010);
    next(); pin("mfhi_stall2", 9'b001101010);
    next(); pin("mfhi_stall3", 9'b001101010);
    next(); pin("mfhi_hilo", 9'b001101011);
    next(); pin("mfhi_adv", 9'b111100000);

    // Branch beats load-use; branch held through a freeze.
    next(); idle_inputs(); bus.ex_branch_taken = 1'b1;
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    pin("flush_wins", 9'b111111000);
    next(); idle_inputs(); bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    pin("freeze_br1", 9'b000000000);
    next(); pin("freeze_br2", 9'b000000000);
    next(); bus.dmem_ready = 1'b1;
    pin("flush_after_freeze", 9'b111111000);

    // div runs through a 3-cycle freeze.
    next(); idle_inputs(); bus.id_md_op = 1'b1; bus.id_md_div = 1'b1;
    pin("div_issue", 9'b111100100);
    for (int i = 1; i <= 3; i++) begin
      next(); idle_inputs(); bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
      pin("div_freeze", 9'b000000010);
    end
    for (int i = 4; i <= 33; i++) begin
      next(); idle_inputs();
      if (i == 32) pin("div_hilo", 9'b111100011);
      else if (i == 33) pin("div_done", 9'b111100000);
    end

    // Reset two cycles into a div abandons it.
    next(); idle_inputs(); bus.id_md_op = 1'b1; bus.id_md_div = 1'b1;
    pin("div2_issue", 9'b111100100);
    next(); idle_inputs();
    pin("div2_busy", 9'b111100010);
    next(); rst_n = 1'b0;
    pin("rst_mid_div", 9'b000011000);
    chk("rst_mid_stall_cnt", bus.stall_cycles, 32'd0);
    chk("rst_mid_flush_cnt", 32'(bus.flush_count), 32'd0);
    next();
    next(); rst_n = 1'b1;
    repeat (40) next();

    // Random traffic with occasional resets.
    repeat (2000) begin
      next();
      rst_n = ($urandom_range(0, 299) != 0);
      random_inputs();
    end
    next(); rst_n = 1'b1; idle_inputs();
    repeat (3) next();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
